// File: rtl/rx_os_lane_counters_pkg.sv
// Shared encodings and types for the receive-side ordered-set lane counter bank.
// The substate encoding is shared with the master RX LTSSM controller.
package rx_os_lane_counters_pkg;

  localparam int unsigned MAXLANES_DEF = 16;
  localparam int unsigned CNT_W_DEF    = 5;
  localparam int unsigned SUBSTATE_W   = 4;
  localparam int unsigned OS_TYPE_W    = 2;
  localparam int unsigned CMP_W        = 5;
  localparam int unsigned NLANES_W     = 5;

  // LTSSM substates, shared with the master RX LTSSM
  typedef enum logic [SUBSTATE_W-1:0] {
    DETECT_QUIET                    = 4'd0,
    DETECT_ACTIVE                   = 4'd1,
    POLLING_ACTIVE                  = 4'd2,
    POLLING_CONFIGURATION           = 4'd3,
    CONFIGURATION_LINKWIDTH_START   = 4'd4,
    CONFIGURATION_LINKWIDTH_ACCEPT  = 4'd5,
    CONFIGURATION_LANENUM_WAIT      = 4'd6,
    CONFIGURATION_LANENUM_ACCEPT    = 4'd7,
    CONFIGURATION_COMPLETE          = 4'd8,
    CONFIGURATION_IDLE              = 4'd9,
    L0                              = 4'd10
  } substate_e;

  // Stored previous substate after reset; no real substate uses it
  localparam logic [SUBSTATE_W-1:0] SUBSTATE_RESET = 4'hF;

  // Decoded ordered-set types
  typedef enum logic [OS_TYPE_W-1:0] {
    OS_OTHER = 2'd0,
    OS_TS1   = 2'd1,
    OS_TS2   = 2'd2,
    OS_IDLE  = 2'd3
  } os_type_e;

  // One lane's decoded ordered-set payload for a single cycle
  typedef struct packed {
    logic     valid;
    os_type_e os_type;
    logic     link_pad;
    logic     lane_pad;
  } lane_os_t;

  // Exit-criterion match for one OS in the given substate; pad_check enables PAD qualifiers
  function automatic logic os_match(input logic [SUBSTATE_W-1:0] substate,
                                    input lane_os_t os,
                                    input logic pad_check);
    logic link_ok;
    logic both_ok;
    logic m;
    link_ok = !(pad_check && os.link_pad);
    both_ok = link_ok && !(pad_check && os.lane_pad);
    m       = 1'b0;
    case (substate)
      POLLING_ACTIVE:                 m = (os.os_type == OS_TS1) || (os.os_type == OS_TS2);
      POLLING_CONFIGURATION:          m = (os.os_type == OS_TS2);
      CONFIGURATION_LINKWIDTH_START,
      CONFIGURATION_LINKWIDTH_ACCEPT: m = (os.os_type == OS_TS1) && link_ok;
      CONFIGURATION_LANENUM_WAIT,
      CONFIGURATION_LANENUM_ACCEPT:   m = (os.os_type == OS_TS1) && both_ok;
      CONFIGURATION_COMPLETE:         m = (os.os_type == OS_TS2) && both_ok;
      CONFIGURATION_IDLE:             m = (os.os_type == OS_IDLE);
      default:                        m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rx_os_lane_counters_if.sv
// Per-lane decoded ordered-set bus from the RX decoders into the counter bank.
interface rx_os_lane_counters_if #(
  parameter int unsigned MAXLANES = 16
);

  logic [MAXLANES-1:0]   osValid;
  logic [2*MAXLANES-1:0] osType;
  logic [MAXLANES-1:0]   osLinkPad;
  logic [MAXLANES-1:0]   osLanePad;

  modport master (
    output osValid,
    output osType,
    output osLinkPad,
    output osLanePad
  );

  modport slave (
    input osValid,
    input osType,
    input osLinkPad,
    input osLanePad
  );

endinterface

// File: rtl/rx_os_lane_counters_lane.sv
// One lane's consecutive-OS counter with saturating count and sticky threshold bit.
// Build option: RX_OS_PAD_CHECK_EN enables the link/lane PAD qualifiers in the match rule.
module rx_os_lane_counter
  import rx_os_lane_counters_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic [SUBSTATE_W-1:0] substate_i,
  input  logic [CMP_W-1:0]      cmp_count_i,
  input  lane_os_t              os_i,
  output logic                  hit_o
);

`ifdef RX_OS_PAD_CHECK_EN
  localparam logic PAD_CHECK = 1'b1;
`else
  localparam logic PAD_CHECK = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             hit_q;
  logic             hit_d;
  logic             match_c;

  assign match_c = os_match(substate_i, os_i, PAD_CHECK);

  // Next count / sticky bit: clear wins, then accepted OS advances or restarts the run
  always_comb begin
    cnt_d = cnt_q;
    hit_d = hit_q;
    if (clear_i) begin
      cnt_d = '0;
      hit_d = 1'b0;
    end else if (os_i.valid) begin
      if (match_c) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
      if ((cmp_count_i != '0) && (32'(cnt_d) >= 32'(cmp_count_i))) begin
        hit_d = 1'b1;
      end
    end
  end

  // Counter and threshold state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      hit_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hit_q <= hit_d;
    end
  end

  assign hit_o = hit_q;

endmodule

// File: rtl/rx_os_lane_counters.sv
// Per-lane ordered-set counter bank for the receive-side LTSSM.
// Holds the shared previous-substate register and lane-active decode; one counter per lane.
// Build option: RX_OS_PAD_CHECK_EN (see rx_os_lane_counter).
module rx_os_lane_counters
  import rx_os_lane_counters_pkg::*;
#(
  parameter int unsigned MAXLANES = MAXLANES_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SUBSTATE_W-1:0] substate,
  input  logic [MAXLANES-1:0]   resetOsCheckers,
  input  logic [CMP_W-1:0]      comparatorsCount,
  input  logic [NLANES_W-1:0]   numberOfDetectedLanes,
  rx_os_lane_counters_if.slave  os_bus,
  output logic [MAXLANES-1:0]   countersComparators
);

  logic [SUBSTATE_W-1:0] prev_substate_q;
  logic                  substate_chg_c;
  logic [MAXLANES-1:0]   lane_active_c;
  logic [MAXLANES-1:0]   lane_clear_c;

  // Previous substate, compared every cycle to detect a substate change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_substate_q <= SUBSTATE_RESET;
    end else begin
      prev_substate_q <= substate;
    end
  end

  assign substate_chg_c = (substate != prev_substate_q);

  for (genvar g = 0; g < MAXLANES; g++) begin : gen_lane
    lane_os_t lane_os;

    assign lane_active_c[g] = (32'(g) < 32'(numberOfDetectedLanes));
    assign lane_clear_c[g]  = !resetOsCheckers[g] || substate_chg_c || !lane_active_c[g];
    assign lane_os          = {os_bus.osValid[g], os_bus.osType[2*g+1:2*g],
                               os_bus.osLinkPad[g], os_bus.osLanePad[g]};

    rx_os_lane_counter #(
      .CNT_W (CNT_W)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (lane_clear_c[g]),
      .substate_i  (substate),
      .cmp_count_i (comparatorsCount),
      .os_i        (lane_os),
      .hit_o       (countersComparators[g])
    );
  end

endmodule
